sync_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences the team's simple dual-port block RAM (dual_port_ram) as a synchronous FIFO.
- Owns the write and read pointers, occupancy count and status flags.
- Drives the RAM write and read ports directly.
- Supports the wide-read mode, where one read pop consumes RD2WR RAM entries.
- A wrapper (sync_fifo) instantiates this controller and dual_port_ram side by side; this block holds no data storage.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/sync_fifo_ctrl.sv | 88 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared parameter helpers for the RAM-backed synchronous FIFO
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Pointers carry one extra bit so full and empty are distinguishable.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit params_ok(
        input int depth,
        input int addr_width,
        input int rd2wr,
        input int afull_th,
        input int aempty_th
    );
        return (depth == (1 << addr_width)) && (addr_width == clog2(depth)) &&
               (rd2wr > 0) && (depth % rd2wr == 0) &&
               (aempty_th < afull_th) && (afull_th <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - pointer, occupancy and flag sequencing for a RAM-backed synchronous FIFO
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RD2WR      = 1,
    parameter int AFULL_TH   = 28,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  rd_valid,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr_port_ena,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_rd_port_ena,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr
);

    localparam int PTR_WIDTH = ptr_width(ADDR_WIDTH);

    localparam logic [PTR_WIDTH-1:0] DEPTH_C   = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] RD_STEP   = PTR_WIDTH'(RD2WR);
    localparam logic [PTR_WIDTH-1:0] AFULL_C   = PTR_WIDTH'(AFULL_TH);
    localparam logic [PTR_WIDTH-1:0] AEMPTY_C  = PTR_WIDTH'(AEMPTY_TH);

    generate
        if (!params_ok(DEPTH, ADDR_WIDTH, RD2WR, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
            $error("sync_fifo_ctrl: inconsistent DEPTH/ADDR_WIDTH/RD2WR/threshold parameters");
        end
    endgenerate

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr_next;
    logic [PTR_WIDTH-1:0] rd_ptr_next;
    logic                 wr_acc;
    logic                 rd_acc;

    assign full         = (data_count == DEPTH_C);
    assign empty        = (data_count < RD_STEP);
    assign almost_full  = (data_count >= AFULL_C);
    assign almost_empty = (data_count <= AEMPTY_C);

    // Accepts look only at registered flags; reset also silences the RAM ports.
    assign wr_acc = rst_n & wr_en & ~full & ~clr;
    assign rd_acc = rst_n & rd_en & ~empty & ~clr;

    assign ram_wr_port_ena = wr_acc;
    assign ram_wr_en       = wr_acc;
    assign ram_wr_addr     = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_rd_port_ena = rd_acc;
    assign ram_rd_addr     = rd_ptr[ADDR_WIDTH-1:0];

    assign wr_ptr_next = wr_acc ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_next = rd_acc ? rd_ptr + RD_STEP : rd_ptr;

    // Flush and reset share the same end state; RAM contents are left alone.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            data_count <= wr_ptr_next - rd_ptr_next;
            rd_valid   <= rd_acc;
            overflow   <= wr_en & full;
            underflow  <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl (narrow and wide-read instances)
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          clr       [2];
    logic          wr_en     [2];
    logic          rd_en     [2];
    logic          full      [2];
    logic          empty     [2];
    logic          afull     [2];
    logic          aempty    [2];
    logic [AW:0]   dcount    [2];
    logic          rd_valid  [2];
    logic          ovf       [2];
    logic          unf       [2];
    logic          wpe       [2];
    logic          we        [2];
    logic [AW-1:0] waddr     [2];
    logic          rpe       [2];
    logic [AW-1:0] raddr     [2];

    sync_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD2WR(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .full(full[0]), .empty(empty[0]), .almost_full(afull[0]), .almost_empty(aempty[0]),
        .data_count(dcount[0]), .rd_valid(rd_valid[0]), .overflow(ovf[0]), .underflow(unf[0]),
        .ram_wr_port_ena(wpe[0]), .ram_wr_en(we[0]), .ram_wr_addr(waddr[0]),
        .ram_rd_port_ena(rpe[0]), .ram_rd_addr(raddr[0])
    );

    sync_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD2WR(2), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .full(full[1]), .empty(empty[1]), .almost_full(afull[1]), .almost_empty(aempty[1]),
        .data_count(dcount[1]), .rd_valid(rd_valid[1]), .overflow(ovf[1]), .underflow(unf[1]),
        .ram_wr_port_ena(wpe[1]), .ram_wr_en(we[1]), .ram_wr_addr(waddr[1]),
        .ram_rd_port_ena(rpe[1]), .ram_rd_addr(raddr[1])
    );

    // Bench-side RAM for the narrow instance so read order can be checked end to end.
    logic [7:0] wdata;
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data;
    always @(posedge clk) begin
        if (we[0]) mem[waddr[0]] <= wdata;
        if (rpe[0]) rd_data <= mem[raddr[0]];
    end

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: occupancy as an integer, addresses modulo DEPTH, data as a queue.
    int         m_cnt [2];
    int         m_wa  [2];
    int         m_ra  [2];
    bit         m_rdv [2];
    bit         m_ovf [2];
    bit         m_unf [2];
    logic [7:0] m_q [$];
    logic [7:0] m_exp;

    function automatic int ratio(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic bit m_full(input int i);
        return m_cnt[i] == DEPTH;
    endfunction
    function automatic bit m_empty(input int i);
        return m_cnt[i] < ratio(i);
    endfunction
    function automatic bit m_wacc(input int i);
        return rst_n && wr_en[i] && !m_full(i) && !clr[i];
    endfunction
    function automatic bit m_racc(input int i);
        return rst_n && rd_en[i] && !m_empty(i) && !clr[i];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit wa;
            bit ra;
            wa = m_wacc(i);
            ra = m_racc(i);
            if (!rst_n || clr[i]) begin
                m_cnt[i] = 0; m_wa[i] = 0; m_ra[i] = 0;
                m_rdv[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
                if (i == 0) m_q.delete();
            end else begin
                m_ovf[i] = wr_en[i] && m_full(i);
                m_unf[i] = rd_en[i] && m_empty(i);
                if (i == 0 && wa) m_q.push_back(wdata);
                if (i == 0 && ra) m_exp = m_q.pop_front();
                if (wa) begin
                    m_wa[i] = (m_wa[i] + 1) % DEPTH;
                    m_cnt[i] = m_cnt[i] + 1;
                end
                if (ra) begin
                    m_ra[i] = (m_ra[i] + ratio(i)) % DEPTH;
                    m_cnt[i] = m_cnt[i] - ratio(i);
                end
                m_rdv[i] = ra;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                string p;
                p = (i == 0) ? "a." : "b.";
                chk({p, "full"},         full[i],     m_full(i));
                chk({p, "empty"},        empty[i],    m_empty(i));
                chk({p, "almost_full"},  afull[i],    m_cnt[i] >= AF);
                chk({p, "almost_empty"}, aempty[i],   m_cnt[i] <= AE);
                chk({p, "data_count"},   dcount[i],   m_cnt[i]);
                chk({p, "rd_valid"},     rd_valid[i], m_rdv[i]);
                chk({p, "overflow"},     ovf[i],      m_ovf[i]);
                chk({p, "underflow"},    unf[i],      m_unf[i]);
                chk({p, "ram_wr_port"},  wpe[i],      m_wacc(i));
                chk({p, "ram_wr_en"},    we[i],       m_wacc(i));
                chk({p, "ram_rd_port"},  rpe[i],      m_racc(i));
                chk({p, "ram_wr_addr"},  waddr[i],    m_wa[i]);
                chk({p, "ram_rd_addr"},  raddr[i],    m_ra[i]);
            end
            if (m_rdv[0]) chk("a.rd_data", rd_data, m_exp);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        wdata = 8'($urandom);
    endtask

    int wrap_exp [8] = '{6, 7, 0, 1, 2, 3, 4, 5};

    initial begin
        int  nvalid;
        bit  first;
        rst_n = 1'b0;
        wdata = 8'h00;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 1'b0; wr_en[i] = 1'b1; rd_en[i] = 1'b1;
        end

        // Reset with both requests held high
        cyc();
        checking = 1;
        cyc();
        cyc();
        chk("rst.count", dcount[0], 0);
        chk("rst.empty", empty[0], 1);
        chk("rst.full", full[0], 0);
        chk("rst.almost_empty", aempty[0], 1);
        chk("rst.rd_valid", rd_valid[0], 0);
        chk("rst.ram_wr_en", we[0], 0);
        chk("rst.b_ram_wr_en", we[1], 0);
        chk("rst.ram_rd_port", rpe[0], 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin wr_en[i] = 1'b0; rd_en[i] = 1'b0; end
        cyc();

        // Fill to full, then one rejected push
        wr_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wdata = 8'(8'h10 + k);
            cyc();
        end
        chk("fill.full", full[0], 1);
        chk("fill.count", dcount[0], 8);
        chk("fill.almost_full", afull[0], 1);
        cyc();
        chk("fill.overflow", ovf[0], 1);
        chk("fill.count_held", dcount[0], 8);
        wr_en[0] = 1'b0;
        cyc();
        chk("fill.overflow_pulse", ovf[0], 0);

        // Drain plus one extra pop
        rd_en[0] = 1'b1;
        nvalid = 0;
        first = 1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            if (rd_valid[0]) begin
                if (first) begin
                    chk("drain.first_data", rd_data, 8'h10);
                    first = 0;
                end
                nvalid++;
            end
        end
        chk("drain.valid_count", nvalid, 8);
        chk("drain.underflow", unf[0], 1);
        chk("drain.empty", empty[0], 1);
        rd_en[0] = 1'b0;
        cyc();
        chk("drain.underflow_pulse", unf[0], 0);

        // Wrap-around: push 6, pop 6, push 8
        wr_en[0] = 1'b1;
        repeat (6) cyc();
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b1;
        repeat (6) cyc();
        rd_en[0] = 1'b0;
        wr_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("wrap.wr_addr", waddr[0], wrap_exp[k]);
            wdata = 8'(8'h40 + k);
            @(posedge clk);
            #1;
        end
        wr_en[0] = 1'b0;
        chk("wrap.full", full[0], 1);
        rd_en[0] = 1'b1;
        repeat (8) cyc();
        rd_en[0] = 1'b0;
        cyc();

        // Simultaneous push and pop at count 3 and at full
        wr_en[0] = 1'b1;
        repeat (3) cyc();
        rd_en[0] = 1'b1;
        repeat (5) cyc();
        chk("simul.count3", dcount[0], 3);
        rd_en[0] = 1'b0;
        repeat (5) cyc();
        chk("simul.full", full[0], 1);
        rd_en[0] = 1'b1;
        cyc();
        chk("simul.full_pop_only", dcount[0], 7);
        repeat (4) cyc();
        chk("simul.count7", dcount[0], 7);
        wr_en[0] = 1'b0;
        repeat (7) cyc();
        rd_en[0] = 1'b0;
        cyc();
        chk("simul.empty", empty[0], 1);

        // Wide read on the RD2WR=2 instance
        wr_en[1] = 1'b1;
        repeat (3) cyc();
        wr_en[1] = 1'b0;
        chk("wide.empty0", empty[1], 0);
        chk("wide.count3", dcount[1], 3);
        chk("wide.rd_addr0", raddr[1], 0);
        rd_en[1] = 1'b1;
        cyc();
        chk("wide.count1", dcount[1], 1);
        chk("wide.empty1", empty[1], 1);
        chk("wide.rd_valid", rd_valid[1], 1);
        cyc();
        chk("wide.underflow", unf[1], 1);
        chk("wide.count_held", dcount[1], 1);
        rd_en[1] = 1'b0;
        wr_en[1] = 1'b1;
        cyc();
        wr_en[1] = 1'b0;
        chk("wide.rd_addr2", raddr[1], 2);
        rd_en[1] = 1'b1;
        cyc();
        rd_en[1] = 1'b0;
        chk("wide.count0", dcount[1], 0);
        chk("wide.rd_addr4", raddr[1], 4);
        cyc();

        // Flush with 5 entries and a read result pending
        wr_en[0] = 1'b1;
        repeat (6) cyc();
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b1;
        cyc();
        chk("clr.count5", dcount[0], 5);
        chk("clr.rd_valid_pending", rd_valid[0], 1);
        clr[0] = 1'b1;
        wr_en[0] = 1'b1;
        #1;
        chk("clr.ram_wr_en", we[0], 0);
        chk("clr.ram_rd_port", rpe[0], 0);
        cyc();
        clr[0] = 1'b0;
        wr_en[0] = 1'b0;
        rd_en[0] = 1'b0;
        chk("clr.count0", dcount[0], 0);
        chk("clr.empty", empty[0], 1);
        chk("clr.rd_valid", rd_valid[0], 0);
        chk("clr.wr_addr", waddr[0], 0);
        cyc();
        chk("clr.push_ignored", dcount[0], 0);

        // Randomised traffic with phases biased toward fill, balance and drain
        for (int c = 0; c < 3000; c++) begin
            int wp;
            wp = ((c / 200) % 3 == 0) ? 80 : (((c / 200) % 3 == 1) ? 50 : 20);
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 2; i++) begin
                wr_en[i] = ($urandom_range(0, 99) < wp);
                rd_en[i] = ($urandom_range(0, 99) < (100 - wp));
                clr[i]   = ($urandom_range(0, 99) == 0);
            end
            cyc();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin wr_en[i] = 1'b0; rd_en[i] = 1'b0; clr[i] = 1'b0; end
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
